// File: rtl/pll_reset_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
// The counter width covers the largest programmed interval.
package pll_reset_pkg;

    typedef enum logic [2:0] {
        S_PLLRST,
        S_WAITLOCK,
        S_STABLE,
        S_MEMREL,
        S_RUN
    } state_t;

    localparam int DEF_RST_PULSE     = 16;
    localparam int DEF_LOCK_TIMEOUT  = 65536;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_STAGE_GAP     = 64;

    localparam logic [3:0] RETRY_MAX = 4'd15;

    function automatic int cnt_width(
        input int a,
        input int b,
        input int c,
        input int d
    );
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Generic two-flop synchroniser for asynchronous status inputs.
// Both stages clear on the synchronous reset.
module bit_sync #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds the PLL in reset, waits for stable lock, then releases
// the memory and system resets in order; retries on lock failure.
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int RST_PULSE     = DEF_RST_PULSE,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int STAGE_GAP     = DEF_STAGE_GAP
) (
    input  logic       i_refclk,
    input  logic       i_rst,
    input  logic       i_pll_locked,
    output logic       o_pll_rst,
    output logic       o_mem_rst,
    output logic       o_sys_rst,
    output logic       o_ready,
    output logic [3:0] o_retries
);

    localparam int CW = cnt_width(RST_PULSE, LOCK_TIMEOUT,
                                  STABLE_CYCLES, STAGE_GAP);

    // Counter reload values: a stage of N cycles counts N-1 down to 0.
    localparam logic [CW-1:0] L_RST = CW'(RST_PULSE - 1);
    localparam logic [CW-1:0] L_TO  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] L_STB = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] L_GAP = CW'(STAGE_GAP - 1);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_retries;
    logic            r_pll_rst;
    logic            r_mem_rst;
    logic            r_sys_rst;
    logic            r_ready;
    logic            w_locked_s;
    logic            w_cnt_zero;
    logic [3:0]      w_retries_inc;

    bit_sync #(
        .WIDTH (1)
    ) u_lock_sync (
        .i_clk (i_refclk),
        .i_rst (i_rst),
        .i_d   (i_pll_locked),
        .o_q   (w_locked_s)
    );

    assign w_cnt_zero    = (r_cnt == '0);
    assign w_retries_inc = (r_retries == RETRY_MAX) ? r_retries
                                                    : r_retries + 4'd1;

    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_state   <= S_PLLRST;
            r_cnt     <= L_RST;
            r_retries <= '0;
            r_pll_rst <= 1'b1;
            r_mem_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_ready   <= 1'b0;
        end else begin
            unique case (r_state)
                S_PLLRST: begin
                    if (w_cnt_zero) begin
                        r_state   <= S_WAITLOCK;
                        r_cnt     <= L_TO;
                        r_pll_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_WAITLOCK: begin
                    // Lock on the timeout edge still counts as lock.
                    if (w_locked_s) begin
                        r_state <= S_STABLE;
                        r_cnt   <= L_STB;
                    end else if (w_cnt_zero) begin
                        r_state   <= S_PLLRST;
                        r_cnt     <= L_RST;
                        r_pll_rst <= 1'b1;
                        r_retries <= w_retries_inc;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!w_locked_s) begin
                        r_state <= S_WAITLOCK;
                        r_cnt   <= L_TO;
                    end else if (w_cnt_zero) begin
                        r_state   <= S_MEMREL;
                        r_cnt     <= L_GAP;
                        r_mem_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_MEMREL: begin
                    if (!w_locked_s) begin
                        r_state   <= S_PLLRST;
                        r_cnt     <= L_RST;
                        r_pll_rst <= 1'b1;
                        r_mem_rst <= 1'b1;
                        r_sys_rst <= 1'b1;
                        r_ready   <= 1'b0;
                        r_retries <= w_retries_inc;
                    end else if (w_cnt_zero) begin
                        r_state   <= S_RUN;
                        r_sys_rst <= 1'b0;
                        r_ready   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    if (!w_locked_s) begin
                        r_state   <= S_PLLRST;
                        r_cnt     <= L_RST;
                        r_pll_rst <= 1'b1;
                        r_mem_rst <= 1'b1;
                        r_sys_rst <= 1'b1;
                        r_ready   <= 1'b0;
                        r_retries <= w_retries_inc;
                    end
                end
                default: begin
                    r_state   <= S_PLLRST;
                    r_cnt     <= L_RST;
                    r_pll_rst <= 1'b1;
                    r_mem_rst <= 1'b1;
                    r_sys_rst <= 1'b1;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    assign o_pll_rst = r_pll_rst;
    assign o_mem_rst = r_mem_rst;
    assign o_sys_rst = r_sys_rst;
    assign o_ready   = r_ready;
    assign o_retries = r_retries;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short intervals
// (pulse 4, timeout 32, stable 8, gap 4).
module tb_pll_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       mem_rst;
    logic       sys_rst;
    logic       ready;
    logic [3:0] retries;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    pll_reset_sequencer #(
        .RST_PULSE     (4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .STAGE_GAP     (4)
    ) dut (
        .i_refclk     (clk),
        .i_rst        (rst),
        .i_pll_locked (pll_locked),
        .o_pll_rst    (pll_rst),
        .o_mem_rst    (mem_rst),
        .o_sys_rst    (sys_rst),
        .o_ready      (ready),
        .o_retries    (retries)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) tick();
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s @edge %0d: observed=%0d expected=%0d",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic do_reset();
        pll_locked = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_pll_rst", int'(pll_rst), 1);
        chk("rst_mem_rst", int'(mem_rst), 1);
        chk("rst_sys_rst", int'(sys_rst), 1);
        chk("rst_ready", int'(ready), 0);
        chk("rst_retries", int'(retries), 0);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        // Clean start: lock sampled at edge 10
        do_reset();
        goto(3);  chk("t1_pll_hi", int'(pll_rst), 1);
        goto(4);  chk("t1_pll_lo", int'(pll_rst), 0);
        goto(9);  pll_locked = 1'b1;
        goto(19); chk("t1_mem_hold", int'(mem_rst), 1);
        goto(20); chk("t1_mem_rel", int'(mem_rst), 0);
                  chk("t1_sys_hold", int'(sys_rst), 1);
        goto(23); chk("t1_sys_hold2", int'(sys_rst), 1);
                  chk("t1_ready_lo", int'(ready), 0);
        goto(24); chk("t1_sys_rel", int'(sys_rst), 0);
                  chk("t1_ready", int'(ready), 1);
                  chk("t1_retries", int'(retries), 0);

        // Lock loss in RUN, then restore
        goto(26); pll_locked = 1'b0;
        goto(28); chk("t4_sys_pre", int'(sys_rst), 0);
                  chk("t4_ready_pre", int'(ready), 1);
        goto(29); chk("t4_sys", int'(sys_rst), 1);
                  chk("t4_mem", int'(mem_rst), 1);
                  chk("t4_ready", int'(ready), 0);
                  chk("t4_pll", int'(pll_rst), 1);
                  chk("t4_retries", int'(retries), 1);
        goto(32); chk("t4_pll_hold", int'(pll_rst), 1);
        goto(33); chk("t4_pll_lo", int'(pll_rst), 0);
                  pll_locked = 1'b1;
        goto(43); chk("t4_mem_hold", int'(mem_rst), 1);
        goto(44); chk("t4_mem_rel", int'(mem_rst), 0);
        goto(47); chk("t4_sys_hold", int'(sys_rst), 1);
        goto(48); chk("t4_sys_rel", int'(sys_rst), 0);
                  chk("t4_ready_up", int'(ready), 1);
                  chk("t4_retries2", int'(retries), 1);

        // Lock glitch during STABLE
        do_reset();
        goto(9);  pll_locked = 1'b1;
        goto(14); pll_locked = 1'b0;
        goto(15); pll_locked = 1'b1;
        goto(17); chk("t3_pll_lo", int'(pll_rst), 0);
        goto(25); chk("t3_mem_hold", int'(mem_rst), 1);
                  chk("t3_pll_lo2", int'(pll_rst), 0);
        goto(26); chk("t3_mem_rel", int'(mem_rst), 0);
                  chk("t3_retries", int'(retries), 0);

        // Lock arrives on the timeout edge
        do_reset();
        goto(33); pll_locked = 1'b1;
        goto(35); chk("t6_pll_pre", int'(pll_rst), 0);
        goto(36); chk("t6_pll_coinc", int'(pll_rst), 0);
                  chk("t6_retries", int'(retries), 0);
        goto(37); chk("t6_pll_post", int'(pll_rst), 0);
        goto(43); chk("t6_mem_hold", int'(mem_rst), 1);
        goto(44); chk("t6_mem_rel", int'(mem_rst), 0);

        // Three timeouts, then rst while in MEMREL
        do_reset();
        goto(35);  chk("t5_pll_pre", int'(pll_rst), 0);
        goto(36);  chk("t5_pll_to1", int'(pll_rst), 1);
                   chk("t5_ret1", int'(retries), 1);
        goto(39);  chk("t5_pll_hold", int'(pll_rst), 1);
        goto(40);  chk("t5_pll_lo", int'(pll_rst), 0);
        goto(72);  chk("t5_ret2", int'(retries), 2);
        goto(108); chk("t5_ret3", int'(retries), 3);
                   chk("t5_pll_to3", int'(pll_rst), 1);
        goto(112); chk("t5_pll_lo3", int'(pll_rst), 0);
                   pll_locked = 1'b1;
        goto(123); chk("t5_mem_rel", int'(mem_rst), 0);
                   chk("t5_sys_hold", int'(sys_rst), 1);
        goto(124); rst = 1'b1;
        goto(125); chk("t5_rst_mem", int'(mem_rst), 1);
                   chk("t5_rst_pll", int'(pll_rst), 1);
                   chk("t5_rst_ret", int'(retries), 0);
                   chk("t5_rst_ready", int'(ready), 0);
        rst = 1'b0;
        cyc = 0;
        goto(3);  chk("t5r_pll_hi", int'(pll_rst), 1);
        goto(4);  chk("t5r_pll_lo", int'(pll_rst), 0);
        goto(12); chk("t5r_mem_hold", int'(mem_rst), 1);
        goto(13); chk("t5r_mem_rel", int'(mem_rst), 0);
        goto(16); chk("t5r_sys_hold", int'(sys_rst), 1);
        goto(17); chk("t5r_sys_rel", int'(sys_rst), 0);
                  chk("t5r_ready", int'(ready), 1);
                  chk("t5r_retries", int'(retries), 0);

        // No lock: retries saturate at 15
        do_reset();
        goto(504); chk("t2_ret14", int'(retries), 14);
                   chk("t2_pll14", int'(pll_rst), 1);
        goto(540); chk("t2_ret15", int'(retries), 15);
                   chk("t2_pll15", int'(pll_rst), 1);
        goto(543); chk("t2_pll_hold", int'(pll_rst), 1);
        goto(544); chk("t2_pll_lo", int'(pll_rst), 0);
        goto(575); chk("t2_pll_pre16", int'(pll_rst), 0);
        goto(576); chk("t2_pll16", int'(pll_rst), 1);
                   chk("t2_sat", int'(retries), 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
